multi_dev_bridge: RTL and testbench
===================================

Name: multi_dev_bridge

Overview:
- Parametrised system bridge between the CPU data-memory port and N_DEV memory-mapped devices (DM, timers, UART, ...).
- Each device window is selected by a base/mask compare.
- Adds a registered request/ack handshake so devices may insert wait states, a bus-error/timeout path, and a registered interrupt vector for CP0.

Parameters:
- N_DEV, 4, number of device slots (1..8).
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- DEV_BASE, {32'h7F20,32'h7F10,32'h7F00,32'h0}, packed N_DEV*ADDR_W base addresses, slot 0 in LSBs.
- DEV_MASK, {32'hFFFFFFF0,32'hFFFFFFF0,32'hFFFFFFF0,32'hFFFFC000}, packed N_DEV*ADDR_W compare masks.
- TIMEOUT, 15, cycles to wait for dev_ack before bus error (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.
- N_IRQ, 6, number of interrupt inputs (1..6).

Ports:
- clk input 1 system clock.
- reset input 1 asynchronous active-high reset.
- cpu_req input 1 access request, sampled in IDLE.
- cpu_we input 1 write enable.
- cpu_addr input ADDR_W byte address.
- cpu_wdata input DATA_W write data.
- cpu_be input DATA_W/8 byte enables.
- cpu_rdata output DATA_W read data, valid with cpu_ready.
- cpu_ready output 1 one-cycle completion pulse.
- cpu_err output 1 error flag, valid with cpu_ready.
- dev_sel output N_DEV one-hot device select, held for the whole access.
- dev_we output 1 device write enable.
- dev_addr output ADDR_W word-aligned address ({addr[ADDR_W-1:2],2'b0}).
- dev_wdata output DATA_W device write data.
- dev_be output DATA_W/8 device byte enables.
- dev_rdata input N_DEV*DATA_W packed device read data.
- dev_ack input N_DEV per-device completion.
- irq_in input N_IRQ device interrupt lines.
- hw_int output 6 registered interrupt vector to CP0.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, timeout counter 0, hw_int 0. An in-flight access is dropped with no ready pulse.
- Decode: hit[i] = ((cpu_addr & DEV_MASK[i]) == DEV_BASE[i]). The lowest hit index wins. No hit is a miss.
- FSM states: IDLE, BUSY, RESP.
- IDLE, cpu_req=1 with a hit:
  - Latch address, wdata, be and we into output registers.
  - Drive dev_sel one-hot. Go to BUSY next edge.
- IDLE, cpu_req=1 with a miss:
  - Go to RESP with err=1 and rdata=ERR_DATA.
  - No dev_sel asserted and no device write.
- BUSY:
  - dev_* outputs stay stable.
  - When dev_ack[sel]=1, capture dev_rdata[sel] (0 on writes), err=0, go to RESP.
  - dev_ack from unselected slots is ignored.
- RESP:
  - cpu_ready=1 for exactly one cycle, with cpu_rdata and cpu_err valid.
  - dev_sel=0 and dev_we=0.
  - Return to IDLE.
- Latency: a device acking in its first BUSY cycle gives cpu_ready 3 cycles after the cpu_req edge. A miss gives cpu_ready 2 cycles after.
- Back-to-back accesses: cpu_req is ignored outside IDLE. A request held high across RESP starts a new access on the IDLE cycle.
- cpu_rdata holds its last value outside RESP. cpu_err is 0 outside RESP.
- Interrupts: hw_int[N_IRQ-1:0] <= irq_in each cycle (one register stage). Upper bits are tied to 0.

Optional Feature:
- BRIDGE_TIMEOUT_EN defined:
  - An 8-bit counter is cleared on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without an ack, go to RESP with err=1 and rdata=ERR_DATA, and drop dev_sel.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- BRIDGE_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for dev_ack.

Decomposition:
- Shared package/def header holds:
  - State encodings (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2).
  - The default ERR_DATA value.
  - Default device base/mask constants (AD_DM, AD_T0, AD_T1, AD_UART).
- One natural sub-module, bridge_addr_decode: combinational base/mask compare plus lowest-index priority encoder. Outputs one-hot sel and a miss flag.

Test Plan:
- Read 0x7F04, slot 1 acks in its 2nd BUSY cycle with rdata 0x1234 -> dev_sel=4'b0010 and dev_addr=0x7F04 while BUSY; cpu_ready pulses once with cpu_rdata=0x1234, cpu_err=0.
- Write 0x0000_0ABC, wdata 0xCAFEF00D, be=4'hF, slot 0 acks immediately -> dev_addr=0x0ABC, dev_we=1 for one BUSY cycle, cpu_ready 3 cycles after request, cpu_err=0.
- Access 0x0000_9000 (miss) -> no dev_sel, cpu_ready 2 cycles later with cpu_err=1, cpu_rdata=0xDEADBEEF.
- With BRIDGE_TIMEOUT_EN, read 0x7F10 with no ack -> after 15 BUSY cycles, cpu_ready with cpu_err=1 and cpu_rdata=0xDEADBEEF; an ack on the 15th cycle gives normal completion.
- Assert reset mid-BUSY -> all outputs 0 immediately (async), no cpu_ready pulse, next request decodes normally.
- irq_in=6'b100101 -> hw_int=6'b100101 one cycle later; toggling dev_ack of an unselected slot during BUSY has no effect.

Source files
------------

// File: rtl/multi_dev_bridge_pkg.sv
// Shared definitions for the multi-device system bridge: FSM state codes,
// the default bus-error read value and the default device address map.
package multi_dev_bridge_pkg;

  // Bridge FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Read data returned on a decode miss or a device timeout
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Default device windows: data memory plus three small I/O blocks
  localparam logic [31:0] AD_DM   = 32'h0000_0000;
  localparam logic [31:0] AD_T0   = 32'h0000_7F00;
  localparam logic [31:0] AD_T1   = 32'h0000_7F10;
  localparam logic [31:0] AD_UART = 32'h0000_7F20;

  localparam logic [31:0] MASK_DM = 32'hFFFF_C000;  // 16 KiB window
  localparam logic [31:0] MASK_IO = 32'hFFFF_FFF0;  // 16-byte register block

  // Packed tables, slot 0 in the LSBs
  localparam logic [127:0] DEV_BASE_DEF = {AD_UART, AD_T1, AD_T0, AD_DM};
  localparam logic [127:0] DEV_MASK_DEF = {MASK_IO, MASK_IO, MASK_IO, MASK_DM};

  // Width of the BUSY-state timeout counter
  localparam int TMO_W = 8;

endpackage

// File: rtl/multi_dev_bridge_addr_decode.sv
// Address decoder for the multi-device bridge: per-slot base/mask compare
// followed by a lowest-index-wins priority encoder. Produces a one-hot
// select and a miss flag when no window matches.
module bridge_addr_decode #(
  parameter int                          N_DEV    = 4,
  parameter int                          ADDR_W   = 32,
  parameter logic [N_DEV*ADDR_W-1:0]     DEV_BASE = '0,
  parameter logic [N_DEV*ADDR_W-1:0]     DEV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_DEV-1:0]  sel,
  output logic              miss
);

  // Scan slots from 0 upward; the first matching window claims the access
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    sel  = '0;
    miss = 1'b1;
    for (int i = 0; i < N_DEV; i++) begin
      if (miss && ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W])) begin
        sel[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_dev_bridge.sv
// System bridge between the CPU data-memory port and N_DEV memory-mapped
// devices. A request is decoded in IDLE, held on the device bus in BUSY
// until the selected device acks, and reported to the CPU with a one-cycle
// cpu_ready pulse in RESP. Misses complete immediately with an error.
// Interrupt lines are registered once into a 6-bit vector for CP0.
//
// Optional feature macro: BRIDGE_TIMEOUT_EN -- when defined, a BUSY access
// with no ack for TIMEOUT cycles completes with a bus error.
module multi_dev_bridge
  import multi_dev_bridge_pkg::*;
#(
  parameter int                      N_DEV    = 4,
  parameter int                      DATA_W   = 32,
  parameter int                      ADDR_W   = 32,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = DEV_BASE_DEF,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = DEV_MASK_DEF,
  parameter int                      TIMEOUT  = 15,
  parameter logic [DATA_W-1:0]       ERR_DATA = ERR_DATA_DEF,
  parameter int                      N_IRQ    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic [DATA_W/8-1:0]     cpu_be,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_we,
  output logic [ADDR_W-1:0]       dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  output logic [DATA_W/8-1:0]     dev_be,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ack,
  input  logic [N_IRQ-1:0]        irq_in,
  output logic [5:0]              hw_int
);

  // Reject unsupported configurations at elaboration
  if (N_DEV < 1 || N_DEV > 8) begin : g_bad_n_dev
    $error("multi_dev_bridge: N_DEV must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("multi_dev_bridge: TIMEOUT must be 1..255");
  end
  if (N_IRQ < 1 || N_IRQ > 6) begin : g_bad_n_irq
    $error("multi_dev_bridge: N_IRQ must be 1..6");
  end

  logic [1:0]        state;
  logic [N_DEV-1:0]  dec_sel;
  logic              dec_miss;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ack;

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  bridge_addr_decode #(
    .N_DEV    (N_DEV),
    .ADDR_W   (ADDR_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .addr (cpu_addr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  // Route the selected device's read data and ack; other slots are ignored
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_sel[i]) sel_rdata = dev_rdata[i*DATA_W +: DATA_W];
    end
    sel_ack = |(dev_ack & dev_sel);
  end

  // Access FSM with registered CPU response and device-bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      dev_sel   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        ST_IDLE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          if (cpu_req) begin
            if (!dec_miss) begin
              dev_sel   <= dec_sel;
              dev_we    <= cpu_we;
              dev_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
              dev_wdata <= cpu_wdata;
              dev_be    <= cpu_be;
`ifdef BRIDGE_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
              state     <= ST_BUSY;
            end else begin
              // Unmapped address: answer straight away with a bus error
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= ERR_DATA;
              state     <= ST_RESP;
            end
          end
        end

        ST_BUSY: begin
          if (sel_ack) begin
            // An ack takes priority over a timeout landing in the same cycle
            cpu_rdata <= dev_we ? '0 : sel_rdata;
            cpu_err   <= 1'b0;
            cpu_ready <= 1'b1;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            state     <= ST_RESP;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            cpu_rdata <= ERR_DATA;
            cpu_err   <= 1'b1;
            cpu_ready <= 1'b1;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          // Single response cycle; cpu_rdata keeps its value afterwards
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          dev_sel   <= '0;
          dev_we    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // One register stage on the interrupt lines; unused upper bits stay 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hw_int <= '0;
    else       hw_int <= 6'(irq_in);
  end

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Self-checking bench for multi_dev_bridge (default parameters). A
// transaction-level model predicts each CPU response from the address map
// and the device behaviour the bench drives; a monitor compares the DUT
// against it every cycle. Directed calls also carry hand-computed results.
// Define BRIDGE_TIMEOUT_EN for both the DUT and this bench to cover timeouts.
module tb_multi_dev_bridge;

  localparam logic [31:0] ERR_WORD    = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_CYC = 15;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_err;
  logic [3:0]   dev_sel;
  logic         dev_we;
  logic [31:0]  dev_addr;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_be;
  logic [127:0] dev_rdata;
  logic [3:0]   dev_ack;
  logic [5:0]   irq_in;
  logic [5:0]   hw_int;

  int checks = 0;
  int errors = 0;

  // Address map as written in the device table
  logic [31:0] win_base [4] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
  logic [31:0] win_mask [4] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

  // Model state: expected responses and the access expected on the device bus
  resp_t       exp_q [$];
  logic [31:0] model_rdata;
  logic [5:0]  hw_model;
  logic [3:0]  act_sel   = '0;
  logic [31:0] act_addr  = '0;
  logic        act_we    = 1'b0;
  logic [31:0] act_wdata = '0;
  logic [3:0]  act_be    = '0;

  multi_dev_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_be    (dev_be),
    .dev_rdata (dev_rdata),
    .dev_ack   (dev_ack),
    .irq_in    (irq_in),
    .hw_int    (hw_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lowest-index matching window, -1 when unmapped
  function automatic int model_slot(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & win_mask[i]) == win_base[i]) return i;
    end
    return -1;
  endfunction

  // Interrupt vector is irq_in delayed by one clock
  always @(posedge clk or posedge reset) begin
    if (reset) hw_model <= '0;
    else       hw_model <= irq_in;
  end

  // Compare process: outputs checked every cycle away from the active edge
  always @(negedge clk) begin
    resp_t r;
    if (reset) begin
      model_rdata = '0;
    end else begin
      check("hw_int", 32'(hw_int), 32'(hw_model));
      if (cpu_ready) begin
        check("ready_dev_sel_low", 32'(dev_sel), 32'd0);
        check("ready_dev_we_low", 32'(dev_we), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_ready", 32'(cpu_ready), 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("model_rdata", cpu_rdata, r.rdata);
          check("model_err", 32'(cpu_err), 32'(r.err));
          model_rdata = r.rdata;
        end
      end else begin
        check("err_outside_resp", 32'(cpu_err), 32'd0);
        check("rdata_hold", cpu_rdata, model_rdata);
      end
      if (dev_sel != 4'd0) begin
        check("dev_sel", 32'(dev_sel), 32'(act_sel));
        check("dev_addr", dev_addr, act_addr);
        check("dev_we", 32'(dev_we), 32'(act_we));
        check("dev_wdata", dev_wdata, act_wdata);
        check("dev_be", 32'(dev_be), 32'(act_be));
      end else begin
        check("dev_we_without_sel", 32'(dev_we), 32'd0);
      end
    end
  end

  // Present every slot's read data: the target gets rd, the others a marker
  task automatic load_rdata(input int slot, input logic [31:0] rd);
    for (int j = 0; j < 4; j++) begin
      dev_rdata[j*32 +: 32] = (j == slot) ? rd : (32'hBAD0_0000 | 32'(j));
    end
  endtask

  // One CPU access. The request is launched just after a clock edge; the
  // target acks in BUSY cycle ack_cyc (0 = never). Latency is the number of
  // edges from the launch edge to the edge at which the CPU sees cpu_ready.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int ack_cyc,
                        input logic [31:0] rd, input logic noise, input int exp_lat,
                        input logic [3:0] exp_sel, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int    slot;
    int    lat;
    int    busy;
    logic  timed_out;
    resp_t r;
    slot      = model_slot(addr);
    timed_out = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    timed_out = (slot >= 0) && (ack_cyc == 0 || ack_cyc > TIMEOUT_CYC);
`endif
    if (slot < 0 || timed_out) r = '{rdata: ERR_WORD, err: 1'b1};
    else                       r = '{rdata: (we ? 32'd0 : rd), err: 1'b0};
    @(posedge clk); #1;
    exp_q.push_back(r);
    if (slot >= 0) begin
      act_sel   = 4'(1 << slot);
      act_addr  = {addr[31:2], 2'b00};
      act_we    = we;
      act_wdata = wdata;
      act_be    = be;
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    load_rdata(slot, rd);
    lat  = 0;
    busy = 0;
    for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        cpu_req = 1'b0;
        check({tag, "_sel_after_decode"}, 32'(dev_sel), 32'(exp_sel));
        if (exp_sel != 4'd0) check({tag, "_addr_after_decode"}, dev_addr, act_addr);
      end
      if (dev_sel != 4'd0) busy++;
      if (cpu_ready) begin
        lat = cyc + 1;
        check({tag, "_rdata"}, cpu_rdata, exp_rdata);
        check({tag, "_err"}, 32'(cpu_err), 32'(exp_err));
      end
      dev_ack = '0;
      if (lat == 0 && slot >= 0) begin
        if (cyc == ack_cyc) dev_ack[slot] = 1'b1;
        if (noise && cyc[0]) dev_ack = dev_ack | ~act_sel;
      end
    end
    dev_ack = '0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy), (exp_sel == 4'd0) ? 32'd0 : 32'(exp_lat - 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_be    = '0;
    dev_rdata = '0;
    dev_ack   = '0;
    irq_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(cpu_ready), 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    check("reset_sel", 32'(dev_sel), 32'd0);
    check("reset_addr", dev_addr, 32'd0);
    check("reset_hw_int", 32'(hw_int), 32'd0);
    reset = 1'b0;

    // Timer 0 read, ack in the 2nd BUSY cycle, other slots toggling their acks
    access("t0_read", 1'b0, 32'h0000_7F04, 32'h0, 4'hF, 2, 32'h0000_1234, 1'b1,
           4, 4'b0010, 32'h0000_1234, 1'b0);
    // DM write acked immediately: rdata forced to 0 despite device data
    access("dm_write", 1'b1, 32'h0000_0ABC, 32'hCAFE_F00D, 4'hF, 1, 32'h5555_5555, 1'b0,
           3, 4'b0001, 32'h0000_0000, 1'b0);
    // Unmapped address
    access("miss_9000", 1'b0, 32'h0000_9000, 32'h0, 4'hF, 1, 32'h0, 1'b0,
           2, 4'b0000, ERR_WORD, 1'b1);
    // UART partial write to an unaligned address
    access("uart_write", 1'b1, 32'h0000_7F23, 32'h0000_00A5, 4'h3, 3, 32'h7777_7777, 1'b1,
           5, 4'b1000, 32'h0000_0000, 1'b0);
    // Top word of the DM window still hits slot 0
    access("dm_top", 1'b0, 32'h0000_3FFC, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 1'b0,
           3, 4'b0001, 32'hA5A5_5A5A, 1'b0);
    // One past the DM window and just past the UART block both miss
    access("miss_4000", 1'b0, 32'h0000_4000, 32'h0, 4'hF, 1, 32'h0, 1'b0,
           2, 4'b0000, ERR_WORD, 1'b1);
    access("miss_7f30", 1'b1, 32'h0000_7F30, 32'h1111_1111, 4'hF, 1, 32'h0, 1'b0,
           2, 4'b0000, ERR_WORD, 1'b1);

`ifdef BRIDGE_TIMEOUT_EN
    access("t1_timeout", 1'b0, 32'h0000_7F10, 32'h0, 4'hF, 0, 32'h0, 1'b0,
           17, 4'b0100, ERR_WORD, 1'b1);
    access("t1_ack_at_limit", 1'b0, 32'h0000_7F18, 32'h0, 4'hF, 15, 32'h0000_0F0F, 1'b0,
           17, 4'b0100, 32'h0000_0F0F, 1'b0);
`else
    access("t1_slow_ack", 1'b0, 32'h0000_7F10, 32'h0, 4'hF, 40, 32'h0000_0F0F, 1'b1,
           42, 4'b0100, 32'h0000_0F0F, 1'b0);
`endif

    // Request held high across RESP: ignored there, re-sampled in IDLE
    @(posedge clk); #1;
    exp_q.push_back('{rdata: ERR_WORD, err: 1'b1});
    exp_q.push_back('{rdata: ERR_WORD, err: 1'b1});
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_9000;
    @(posedge clk); #1;
    check("b2b_first_ready", 32'(cpu_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_idle_gap", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    check("b2b_second_ready", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("b2b_done", 32'(cpu_ready), 32'd0);

    // Reset in the middle of a BUSY access
    irq_in = 6'b010010;
    @(posedge clk); #1;
    act_sel   = 4'b0100;
    act_addr  = 32'h0000_7F14;
    act_we    = 1'b0;
    act_wdata = 32'h0;
    act_be    = 4'hF;
    cpu_req   = 1'b1;
    cpu_addr  = 32'h0000_7F14;
    cpu_wdata = 32'h0;
    cpu_be    = 4'hF;
    load_rdata(2, 32'h0000_9999);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check("rst_busy_sel", 32'(dev_sel), 32'h4);
    check("rst_prev_hw_int", 32'(hw_int), 32'h12);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_async_sel", 32'(dev_sel), 32'd0);
    check("rst_async_addr", dev_addr, 32'd0);
    check("rst_async_rdata", cpu_rdata, 32'd0);
    check("rst_async_ready", 32'(cpu_ready), 32'd0);
    check("rst_async_hw_int", 32'(hw_int), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_late_ready", 32'(cpu_ready), 32'd0);

    // Interrupt vector: visible one edge after irq_in changes
    irq_in = 6'b100101;
    check("irq_before_edge", 32'(hw_int), 32'h12);
    @(posedge clk); #1;
    check("irq_after_edge", 32'(hw_int), 32'h25);

    // First access after reset decodes normally
    access("post_rst_t0", 1'b0, 32'h0000_7F08, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, 1'b1,
           3, 4'b0010, 32'h0BAD_CAFE, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
